// File: rtl/seq_divider_if.sv
// Request/response bundle between the ALU and a sequential divider.
// The divider sits on the slave modport and the ALU on the master modport.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;

  modport slave (
    input  s_axis_dividend_tdata,
    input  s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata,
    input  s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    output m_axis_dout_tdata,
    output m_axis_dout_tvalid
  );

  modport master (
    output s_axis_dividend_tdata,
    output s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata,
    output s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    input  m_axis_dout_tdata,
    input  m_axis_dout_tvalid
  );
endinterface

// File: rtl/seq_divider.sv
// Radix-2 restoring divider, one quotient bit per cycle, MSB first.
// Signed mode divides magnitudes and fixes signs on the final step.
module seq_divider #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  seq_divider_if.slave  bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [WIDTH-1:0]   quo_reg;
  logic [WIDTH-1:0]   rem_reg;
  logic [WIDTH-1:0]   dvs_reg;
  logic [WIDTH-1:0]   dividend_reg;
  logic               q_neg_reg;
  logic               r_neg_reg;
  logic               dvs_zero_reg;
  logic               ready_reg;
  logic               valid_reg;
  logic [2*WIDTH-1:0] dout_reg;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               accept;

  assign a_neg  = SIGNED && bus.s_axis_dividend_tdata[WIDTH-1];
  assign b_neg  = SIGNED && bus.s_axis_divisor_tdata[WIDTH-1];
  assign a_mag  = a_neg ? -bus.s_axis_dividend_tdata : bus.s_axis_dividend_tdata;
  assign b_mag  = b_neg ? -bus.s_axis_divisor_tdata  : bus.s_axis_divisor_tdata;
  assign accept = ready_reg && bus.s_axis_dividend_tvalid && bus.s_axis_divisor_tvalid;

  // One restoring step: quo_reg shifts the dividend out while quotient bits shift in.
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     trial;
  logic               step_ok;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
  logic [2*WIDTH-1:0] result_next;

  assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_reg};
  assign step_ok  = ~trial[WIDTH];
  assign rem_next = step_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo_reg[WIDTH-2:0], step_ok};

  assign q_fix = q_neg_reg ? -quo_next : quo_next;
  assign r_fix = r_neg_reg ? -rem_next : rem_next;

  // A zero divisor bypasses the sign fix-up so the quotient stays all ones.
  assign result_next = dvs_zero_reg ? {{WIDTH{1'b1}}, dividend_reg} : {q_fix, r_fix};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      count_reg    <= '0;
      quo_reg      <= '0;
      rem_reg      <= '0;
      dvs_reg      <= '0;
      dividend_reg <= '0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      dvs_zero_reg <= 1'b0;
      ready_reg    <= 1'b1;
      valid_reg    <= 1'b0;
      dout_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            quo_reg      <= a_mag;
            rem_reg      <= '0;
            dvs_reg      <= b_mag;
            dividend_reg <= bus.s_axis_dividend_tdata;
            q_neg_reg    <= a_neg ^ b_neg;
            r_neg_reg    <= a_neg;
            dvs_zero_reg <= (bus.s_axis_divisor_tdata == '0);
            count_reg    <= '0;
            ready_reg    <= 1'b0;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          quo_reg   <= quo_next;
          rem_reg   <= rem_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == CW'(WIDTH - 1)) begin
            dout_reg  <= result_next;
            valid_reg <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.s_axis_dividend_tready = ready_reg;
  assign bus.s_axis_divisor_tready  = ready_reg;
  assign bus.m_axis_dout_tdata      = dout_reg;
  assign bus.m_axis_dout_tvalid     = valid_reg;

endmodule
